// File: rtl/pll_clk_rst_seq_pkg.sv
// Shared types and constants for the per-domain PLL clock/reset sequencer.
// Divider widths match the control register block's PLL_CONFIG fields.
package pll_clk_rst_seq_pkg;

    localparam int REF_DIV_BW = 4;
    localparam int FB_DIV_BW  = 12;

    typedef enum logic [2:0] {
        ST_RST_ON = 3'd0,
        ST_GATE   = 3'd1,
        ST_LOCK   = 3'd2,
        ST_RUN    = 3'd3,
        ST_STOP   = 3'd4,
        ST_ERR    = 3'd5
    } clk_rst_state_e;

    typedef struct packed {
        logic [REF_DIV_BW-1:0] ref_div;
        logic [FB_DIV_BW-1:0]  fb_div;
    } pll_cfg_t;

    localparam pll_cfg_t PLL_CFG_RST = '{ref_div: REF_DIV_BW'(1), fb_div: FB_DIV_BW'(1)};

    // A zero divider would stall the PLL, so it is forced to 1 when latched.
    function automatic pll_cfg_t sat_cfg(input pll_cfg_t cfg);
        pll_cfg_t res;
        res = cfg;
        if (cfg.ref_div == REF_DIV_BW'(0)) begin
            res.ref_div = REF_DIV_BW'(1);
        end else begin
            res.ref_div = cfg.ref_div;
        end
        if (cfg.fb_div == FB_DIV_BW'(0)) begin
            res.fb_div = FB_DIV_BW'(1);
        end else begin
            res.fb_div = cfg.fb_div;
        end
        return res;
    endfunction

    // Returns {clk_en, rst_n} for a state.
    function automatic logic [1:0] state_outs(input clk_rst_state_e st);
        logic [1:0] res;
        case (st)
            ST_RST_ON: res = 2'b10;
            ST_GATE:   res = 2'b00;
            ST_LOCK:   res = 2'b00;
            ST_RUN:    res = 2'b11;
            ST_STOP:   res = 2'b01;
            ST_ERR:    res = 2'b00;
            default:   res = 2'b00;
        endcase
        return res;
    endfunction

    function automatic logic state_busy(input clk_rst_state_e st);
        logic res;
        case (st)
            ST_RUN:  res = 1'b0;
            ST_STOP: res = 1'b0;
            ST_ERR:  res = 1'b0;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lock_sync_filt.sv
// Two-flop synchroniser for the asynchronous PLL lock, followed by a
// consecutive-high filter; locked asserts after LOCK_FILT synced-high samples.
module lock_sync_filt #(
    parameter int LOCK_FILT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic lock_async,
    output logic locked
);

    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILT);

    logic              sync1_r;
    logic              sync2_r;
    logic [FILT_W-1:0] cnt_r;
    logic [FILT_W-1:0] cnt_nxt_s;
    logic              locked_r;

    // Filter count: cleared by any low sample or an external clear, saturates at FILT_MAX.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr || !sync2_r) begin
            cnt_nxt_s = FILT_W'(0);
        end else if (cnt_r != FILT_MAX) begin
            cnt_nxt_s = cnt_r + FILT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Synchroniser, filter count and registered locked flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            cnt_r    <= FILT_W'(0);
            locked_r <= 1'b0;
        end else begin
            sync1_r  <= lock_async;
            sync2_r  <= sync1_r;
            cnt_r    <= cnt_nxt_s;
            locked_r <= (cnt_nxt_s == FILT_MAX);
        end
    end

    assign locked = locked_r;

endmodule

// File: rtl/pll_clk_rst_seq.sv
// Per-domain clock/reset sequencer: walks one PLL and its clock domain through
// reset, gate, reprogram, lock, enable and release.
module pll_clk_rst_seq
    import pll_clk_rst_seq_pkg::*;
#(
    parameter int RST_HOLD_CYC = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_FILT    = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [REF_DIV_BW-1:0] cfg_ref_div_i,
    input  logic [FB_DIV_BW-1:0]  cfg_fb_div_i,
    input  logic                  cfg_update_i,
    input  logic                  cfg_clk_en_i,
    input  logic                  cfg_rst_i,
    input  logic                  pll_lock_i,
    output logic [REF_DIV_BW-1:0] pll_ref_div_o,
    output logic [FB_DIV_BW-1:0]  pll_fb_div_o,
    output logic                  clk_en_o,
    output logic                  rst_no,
    output logic                  busy_o,
    output logic                  lock_err_o
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYC + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

    clk_rst_state_e    state_r;
    clk_rst_state_e    state_nxt_s;
    pll_cfg_t          shadow_r;
    pll_cfg_t          pll_cfg_r;
    logic              pend_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              hold_done_s;
    logic              tmo_done_s;
    logic              locked_s;
    logic              filt_clr_s;
    logic              clk_en_r;
    logic              rst_n_r;
    logic              busy_r;
    logic              lock_err_r;

    assign hold_done_s = (hold_cnt_r == HOLD_LAST);
    assign tmo_done_s  = (tmo_cnt_r == TMO_LAST);
    assign filt_clr_s  = (state_r == ST_GATE);

    lock_sync_filt #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_sync_filt (
        .clk        (clk_i),
        .rst_n      (arst_ni),
        .clr        (filt_clr_s),
        .lock_async (pll_lock_i),
        .locked     (locked_s)
    );

    // Next-state selection; cfg_rst_i only matters where the domain is not already in reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RST_ON: begin
                if (hold_done_s) begin
                    state_nxt_s = pend_r ? ST_GATE : ST_RUN;
                end else begin
                    state_nxt_s = ST_RST_ON;
                end
            end
            ST_GATE: state_nxt_s = ST_LOCK;
            ST_LOCK: begin
                if (pend_r) begin
                    state_nxt_s = ST_GATE;
                end else if (locked_s) begin
                    state_nxt_s = ST_RST_ON;
                end else if (tmo_done_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            ST_RUN: begin
                if (pend_r || cfg_rst_i) begin
                    state_nxt_s = ST_RST_ON;
                end else if (!cfg_clk_en_i) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOP: begin
                // A gated clock cannot carry a reset, so resets take the relock path.
                if (pend_r || cfg_rst_i) begin
                    state_nxt_s = ST_GATE;
                end else if (cfg_clk_en_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_ERR: begin
                if (pend_r) begin
                    state_nxt_s = ST_GATE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: state_nxt_s = ST_GATE;
        endcase
    end

    // State register with outputs decoded from the next state so they switch on state entry.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r    <= ST_LOCK;
            clk_en_r   <= 1'b0;
            rst_n_r    <= 1'b0;
            busy_r     <= 1'b1;
            lock_err_r <= 1'b0;
        end else begin
            state_r               <= state_nxt_s;
            {clk_en_r, rst_n_r}   <= state_outs(state_nxt_s);
            busy_r                <= state_busy(state_nxt_s);
            if (state_nxt_s == ST_GATE) begin
                lock_err_r <= 1'b0;
            end else if ((state_r == ST_LOCK) && (state_nxt_s == ST_ERR)) begin
                lock_err_r <= 1'b1;
            end else begin
                lock_err_r <= lock_err_r;
            end
        end
    end

    // Reset-hold and lock-timeout counters, each idle at zero outside its state.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            hold_cnt_r <= HOLD_W'(0);
            tmo_cnt_r  <= TMO_W'(0);
        end else begin
            if ((state_r == ST_RST_ON) && !hold_done_s) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= HOLD_W'(0);
            end
            if ((state_r == ST_LOCK) && !tmo_done_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= TMO_W'(0);
            end
        end
    end

    // Shadow dividers and pending flag; an update on the GATE entry edge still wins.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            shadow_r  <= PLL_CFG_RST;
            pll_cfg_r <= PLL_CFG_RST;
            pend_r    <= 1'b0;
        end else begin
            if (cfg_update_i) begin
                shadow_r <= sat_cfg('{ref_div: cfg_ref_div_i, fb_div: cfg_fb_div_i});
                pend_r   <= 1'b1;
            end else if (state_nxt_s == ST_GATE) begin
                shadow_r <= shadow_r;
                pend_r   <= 1'b0;
            end else begin
                shadow_r <= shadow_r;
                pend_r   <= pend_r;
            end
            if (state_nxt_s == ST_GATE) begin
                pll_cfg_r <= shadow_r;
            end else begin
                pll_cfg_r <= pll_cfg_r;
            end
        end
    end

    assign pll_ref_div_o = pll_cfg_r.ref_div;
    assign pll_fb_div_o  = pll_cfg_r.fb_div;
    assign clk_en_o      = clk_en_r;
    assign rst_no        = rst_n_r;
    assign busy_o        = busy_r;
    assign lock_err_o    = lock_err_r;

endmodule
